auth_requester: RTL

- ATM session controller; the initiator side of the account-authentication interface.
- Latches card/account and PIN entries from the front panel and drives account/PIN/action requests to the combinational account authenticator.
- Samples that authenticator's success flag and index, then owns the session lifecycle: retry counting, lockout, inactivity timeout and de-authentication.
- Sits between the keypad/front-panel logic and the authenticator; downstream transaction logic consumes session_active/session_idx.

---
 rtl/atm_pkg.sv | 35 +++
 rtl/auth_requester_if.sv | 33 +++
 rtl/atm_timer.sv | 38 +++
 rtl/auth_requester.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and constants for the ATM session controller
// Contents: session state enum, authenticator action codes, bus widths,
//           the PARK value and a helper telling which states drive the bus.
package atm_pkg;

  localparam int ACC_W = 4;
  localparam int PIN_W = 4;

  localparam logic ACT_FIND = 1'b0;
  localparam logic ACT_AUTH = 1'b1;

  // Idle value on acc_number/pin; forces the authenticator to re-evaluate
  // on every new request, even after deAuth has left its flag undefined.
  localparam logic [3:0] PARK = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FIND_REQ,
    FIND_CHK,
    WAIT_PIN,
    AUTH_REQ,
    AUTH_CHK,
    SESSION,
    LOCKED
  } state_t;

  function automatic logic drives_bus(state_t s);
    return (s == FIND_REQ) || (s == FIND_CHK) || (s == AUTH_REQ) || (s == AUTH_CHK);
  endfunction

  function automatic logic is_auth(state_t s);
    return (s == AUTH_REQ) || (s == AUTH_CHK);
  endfunction

endpackage

// File: rtl/auth_requester_if.sv
// rtl/auth_requester_if.sv - request/response bus to the account authenticator
// Signals:
//   acc_number, pin, action, deAuth : requester -> authenticator
//   wasSuccessful, accIndex         : authenticator -> requester
// Modports: master (requester side), slave (authenticator side).
interface auth_requester_if;

  logic [atm_pkg::ACC_W-1:0] acc_number;
  logic [atm_pkg::PIN_W-1:0] pin;
  logic                      action;
  logic                      deAuth;
  logic                      wasSuccessful;
  logic [3:0]                accIndex;

  modport master (
    output acc_number,
    output pin,
    output action,
    output deAuth,
    input  wasSuccessful,
    input  accIndex
  );

  modport slave (
    input  acc_number,
    input  pin,
    input  action,
    input  deAuth,
    output wasSuccessful,
    output accIndex
  );

endinterface

// File: rtl/atm_timer.sv
// rtl/atm_timer.sv - loadable/clearable saturating cycle counter with terminal compare
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr              : synchronous clear to zero (highest priority)
//   load, load_val   : synchronous load
//   inc              : count up by one, holding at all-ones
//   term             : terminal value to compare against
//   at_term          : current count equals term
module atm_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/auth_requester.sv
// rtl/auth_requester.sv - ATM session controller, initiator side of account authentication
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   card_valid, acc_in    : new card/account entry strobe and value
//   pin_valid, pin_in     : completed PIN entry strobe and value
//   logout, activity      : session end request, session keep-alive
//   auth                  : authenticator bus (master modport)
//   session_active        : high while a session is open
//   session_idx           : authenticator index latched at login
//   auth_fail, timeout    : single-cycle event pulses
//   locked                : high while in lockout
module auth_requester
  import atm_pkg::*;
#(
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCK_CYC    = 5000,
  parameter int TIMER_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_valid,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             logout,
  input  logic             activity,
  auth_requester_if.master auth,
  output logic             session_active,
  output logic [3:0]       session_idx,
  output logic             auth_fail,
  output logic             timeout,
  output logic             locked
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [TRY_W-1:0]   tries_q, tries_d, tries_inc;
  logic [3:0]         idx_d;
  logic               fail_d, tmo_d, deauth_d;
  logic               tmr_clr, tmr_inc, tmr_at_term;
  logic [TIMER_W-1:0] tmr_term;

  // One timer serves both idle timeouts and the lockout hold.
  assign tmr_term  = (state_q == LOCKED) ? TIMER_W'(LOCK_CYC - 1) : TIMER_W'(TIMEOUT_CYC - 1);
  assign tries_inc = tries_q + 1'b1;

  atm_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ({TIMER_W{1'b0}}),
    .inc      (tmr_inc),
    .term     (tmr_term),
    .at_term  (tmr_at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pin_q   <= '0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pin_q   <= pin_d;
      tries_q <= tries_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pin_d    = pin_q;
    tries_d  = tries_q;
    idx_d    = session_idx;
    fail_d   = 1'b0;
    tmo_d    = 1'b0;
    deauth_d = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (card_valid) begin
          acc_d   = acc_in;
          state_d = FIND_REQ;
        end
      end
      FIND_REQ: state_d = FIND_CHK;
      FIND_CHK: begin
        if (auth.wasSuccessful) begin
          state_d = WAIT_PIN;
          tmr_clr = 1'b1;
          tries_d = '0;
        end else begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_PIN: begin
        tmr_inc = 1'b1;
        if (pin_valid) begin
          pin_d   = pin_in;
          state_d = AUTH_REQ;
        end else if (tmr_at_term) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      AUTH_REQ: state_d = AUTH_CHK;
      AUTH_CHK: begin
        tmr_clr = 1'b1;
        if (auth.wasSuccessful) begin
          idx_d   = auth.accIndex;
          tries_d = '0;
          state_d = SESSION;
        end else begin
          fail_d  = 1'b1;
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_W'(MAX_TRIES)) ? LOCKED : WAIT_PIN;
        end
      end
      SESSION: begin
        if (logout) begin
          deauth_d = 1'b1;
          state_d  = IDLE;
        end else if (activity) begin
          tmr_clr = 1'b1;
        end else if (tmr_at_term) begin
          deauth_d = 1'b1;
          tmo_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      LOCKED: begin
        if (tmr_at_term) begin
          tries_d = '0;
          state_d = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth.acc_number <= PARK;
      auth.pin        <= PARK;
      auth.action     <= ACT_FIND;
      auth.deAuth     <= 1'b0;
      session_active  <= 1'b0;
      session_idx     <= '0;
      auth_fail       <= 1'b0;
      timeout         <= 1'b0;
      locked          <= 1'b0;
    end else begin
      auth.acc_number <= drives_bus(state_d) ? acc_d : PARK;
      auth.pin        <= drives_bus(state_d) ? pin_d : PARK;
      auth.action     <= is_auth(state_d) ? ACT_AUTH : ACT_FIND;
      auth.deAuth     <= deauth_d;
      session_active  <= (state_d == SESSION);
      session_idx     <= idx_d;
      auth_fail       <= fail_d;
      timeout         <= tmo_d;
      locked          <= (state_d == LOCKED);
    end
  end

endmodule
